// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: byte-addressed backing store answering cache word requests
// after a fixed latency, with a one-cycle mem_ready completion pulse.
module main_memory_ctrl #(
    parameter int ADDR_BITS = 16,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in [0:3],
    output logic [7:0]  mem_data_out [0:3],
    output logic        mem_ready
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    localparam int IW = ADDR_BITS - 2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q [0:3];
    logic [7:0]    wdata_d [0:3];
    logic [7:0]    rdata_q [0:3];
    logic [7:0]    rdata_d [0:3];
    logic          commit;
    logic          addr_unused;
    // Contents survive reset; only the power-up value is zero.
    logic [7:0]    mem [0:(1<<ADDR_BITS)-1] = '{default: 8'h00};

    assign addr_unused = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        if (state_q == IDLE && mem_req) begin
            idx_d   = mem_addr[ADDR_BITS-1:2];
            we_d    = mem_write_en;
            wdata_d = mem_data_in;
            cnt_d   = 4'(LATENCY - 1);
            commit  = (LATENCY == 1);
            state_d = commit ? DONE : BUSY;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - 4'd1;
            commit  = (cnt_q == 4'd1);
            state_d = commit ? DONE : BUSY;
        end else begin
            state_d = IDLE;
        end
        // idx_d/we_d/wdata_d hold the live request on a LATENCY==1 accept and the latched copy otherwise.
        if (commit && !we_d)
            for (int k = 0; k < 4; k++) rdata_d[k] = mem[{idx_d, 2'(k)}];
    end

    always @(posedge clk)
        if (rst_b && commit && we_d)
            for (int k = 0; k < 4; k++) mem[{idx_d, 2'(k)}] <= wdata_d[k];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '{default: 8'h00};
            rdata_q <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_ready    = (state_q == DONE);
    assign mem_data_out = rdata_q;
endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: table-driven, scoreboarded check of main_memory_ctrl
// at LATENCY=4 (u0) and LATENCY=1 (u1).
module tb_main_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdat0 = '0, wdat1 = '0;
    logic [31:0] rword0, rword1;
    logic        rdy0, rdy1;
    logic [7:0]  din0 [0:3];
    logic [7:0]  din1 [0:3];
    logic [7:0]  dout0 [0:3];
    logic [7:0]  dout1 [0:3];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    always_comb begin
        rword0 = '0;
        rword1 = '0;
        for (int k = 0; k < 4; k++) begin
            din0[k] = wdat0[31-8*k -: 8];
            din1[k] = wdat1[31-8*k -: 8];
            rword0[31-8*k -: 8] = dout0[k];
            rword1[31-8*k -: 8] = dout1[k];
        end
    end

    main_memory_ctrl u0 (.clk(clk), .rst_b(rst_b), .mem_req(req0), .mem_write_en(we0),
        .mem_addr(addr0), .mem_data_in(din0), .mem_data_out(dout0), .mem_ready(rdy0));
    main_memory_ctrl #(.ADDR_BITS(16), .LATENCY(1)) u1 (.clk(clk), .rst_b(rst_b), .mem_req(req1),
        .mem_write_en(we1), .mem_addr(addr1), .mem_data_in(din1), .mem_data_out(dout1), .mem_ready(rdy1));

    typedef struct {
        int          s;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        scr;
        logic [31:0] e;
    } vec_t;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
        if (s == 0) begin
            req0 = r; addr0 = a; we0 = w; wdat0 = d;
        end else begin
            req1 = r; addr1 = a; we1 = w; wdat1 = d;
        end
    endtask

    function automatic logic rdy_of(input int s);
        return (s == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [31:0] rw_of(input int s);
        return (s == 0) ? rword0 : rword1;
    endfunction

    // One request; scr perturbs the request inputs while the DUT is busy.
    task automatic xact(input vec_t v);
        int lat;
        @(negedge clk);
        drive(v.s, 1'b1, v.a, v.w, v.d);
        sb.push_back(v.e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && v.scr && !rdy_of(v.s)) drive(v.s, 1'b1, 32'h80, 1'b1, 32'h5555_AAAA);
        end while (!rdy_of(v.s) && lat < 40);
        drive(v.s, 1'b0, '0, 1'b0, '0);
        check("latency", 32'(lat), (v.s == 0) ? 32'd4 : 32'd1);
        check("rdata", rw_of(v.s), sb.pop_front());
        @(negedge clk);
        check("ready_width", {31'b0, rdy_of(v.s)}, 32'd0);
    endtask

    vec_t vt [16];

    initial begin
        int c, n;
        vt = '{
            '{0, 32'h0000_0010, 1'b0, 32'h0,         1'b0, 32'h0},
            '{0, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0},
            '{0, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF},
            '{0, 32'h0000_0043, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF},
            '{0, 32'h0000_0100, 1'b1, 32'h0102_0304, 1'b0, 32'hDEAD_BEEF},
            '{0, 32'h0000_FFFC, 1'b1, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF},
            '{0, 32'h0000_0101, 1'b0, 32'h0,         1'b0, 32'h0102_0304},
            '{0, 32'hABCD_FFFF, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D},
            '{0, 32'h0000_0020, 1'b0, 32'h0,         1'b0, 32'h0},
            '{0, 32'h0000_0040, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF},
            '{0, 32'h0000_0080, 1'b0, 32'h0,         1'b0, 32'h0},
            '{0, 32'h0000_0020, 1'b1, 32'hA1B2_C3D4, 1'b0, 32'h0},
            '{1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'h0},
            '{1, 32'h0001_0040, 1'b1, 32'h1122_3344, 1'b0, 32'h0},
            '{1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'h1122_3344},
            '{1, 32'h0000_0042, 1'b0, 32'h0,         1'b0, 32'h1122_3344}
        };
        repeat (3) @(negedge clk);
        check("rst_ready0", {31'b0, rdy0}, 32'd0);
        check("rst_ready1", {31'b0, rdy1}, 32'd0);
        check("rst_data0", rword0, 32'd0);
        check("rst_data1", rword1, 32'd0);
        rst_b = 1'b1;
        foreach (vt[i]) xact(vt[i]);

        // Continuous request: three reads, one pulse every LATENCY+1 cycles.
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_0100, 1'b0, '0);
        repeat (3) sb.push_back(32'h0102_0304);
        c = 0;
        n = 0;
        while (n < 3 && c < 40) begin
            @(negedge clk);
            c++;
            if (rdy0) begin
                n++;
                check("b2b_time", 32'(c), 32'(4 + 5 * (n - 1)));
                check("b2b_data", rword0, sb.pop_front());
                if (n == 3) drive(0, 1'b0, '0, 1'b0, '0);
            end
        end
        check("b2b_count", 32'(n), 32'd3);
        @(negedge clk);
        check("b2b_idle", {31'b0, rdy0}, 32'd0);

        // Reset during BUSY of a write aborts it silently.
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_0020, 1'b1, 32'h1122_3344);
        repeat (2) begin
            @(negedge clk);
            check("abort_noready", {31'b0, rdy0}, 32'd0);
        end
        rst_b = 1'b0;
        #1;
        check("abort_ready", {31'b0, rdy0}, 32'd0);
        check("abort_data", rword0, 32'd0);
        drive(0, 1'b0, '0, 1'b0, '0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold", {31'b0, rdy0}, 32'd0);
        end
        rst_b = 1'b1;
        xact('{0, 32'h0000_0020, 1'b0, 32'h0, 1'b0, 32'hA1B2_C3D4});
        xact('{0, 32'h0000_0040, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
